add_round_key_sched: RTL and testbench
======================================

# add_round_key_sched

AddRoundKey stage with an integrated on-the-fly AES-128 key schedule. It sits directly downstream of the registered MixColumns stage, which produces its output one clock after its input. Each accepted 128-bit state is XORed with the current round key, and the key then advances to the next round key. After the tenth round the key rewinds to the cipher key, so the block is ready for the next data block without reloading.

## Interface
- `NR`, default 10: number of rounds; the round index runs from 0 to NR.
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: **asynchronous, active-low reset**. One clock domain only; no other clocks.
- `key_load`, in, 1: single-cycle pulse that captures `key_in` as round key 0.
- `key_in`, in, 128: cipher key.
- `in_valid`, in, 1: `data_in` is valid this cycle.
- `in_ready`, out, 1: the block accepts `data_in` this cycle.
- `data_in`, in, 128: state to be keyed.
- `out_valid`, out, 1: `data_out` is valid.
- `out_ready`, in, 1: the downstream stage accepts `data_out`.
- `data_out`, out, 128: `data_in` XOR the current round key.
- `out_round`, out, 4: round index (0 to NR) of the key applied to `data_out`.
- `key_ready`, out, 1: a key is loaded.

## Operation
- **State packing.** Column c occupies bits [32c+31:32c]. Row r of a column is byte [8r+7:8r]. Key word w0 is [31:0] and w3 is [127:96]. Byte 0 of the FIPS-197 key string sits at [7:0].
- **Registers.**
  - `k0`: the saved cipher key.
  - `rk`: the current round key.
  - `rnd`: the round counter, 0 to NR.
  - The output register: `data_out`, `out_round`, `out_valid`.
- **Key load.** When `key_load`=1: `k0` and `rk` take `key_in`, `rnd` goes to 0, and `key_ready` goes to 1.
  - `key_load` has priority over a same-cycle handshake, which is dropped.
  - `out_valid` is cleared in the same cycle.
- **Accept rule.** `in_ready` = `key_ready` & !`key_load` & (!`out_valid` | `out_ready`).
- **On accept** (`in_valid` & `in_ready`):
  - `data_out` takes `data_in` ^ `rk`, `out_round` takes `rnd`, and `out_valid` goes to 1.
  - If `rnd` < NR: `rk` takes next_key(`rk`, rcon[`rnd`]) and `rnd` increments.
  - If `rnd` = NR: `rk` takes `k0` and `rnd` goes to 0 (wrap-around).
- **next_key.** t = SubWord(RotWord(w3)) ^ {24'h0, rcon}, where RotWord(w) = {w[7:0], w[31:8]}. Then w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- **Rcon** for `rnd` 0 to 9: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- **Output drain.** If `out_valid` & `out_ready` and there is no new accept, `out_valid` goes to 0.
- **Backpressure.** While `out_valid` & !`out_ready`, `data_out` and `out_round` hold, and `rk` and `rnd` do not advance.
- **Reset values.** `data_out`=0, `out_round`=0, `out_valid`=0, `key_ready`=0, `rk`=0, `k0`=0, `rnd`=0.
  - Reset during a block abandons it. A new `key_load` is required before any further accept.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on `data_out` after edge N.
- Throughput is 1 beat/cycle while `out_ready`=1, including across the round NR to round 0 wrap.
- `in_ready` is combinational from `out_valid`, `out_ready`, `key_ready` and `key_load`. There is no combinational path from `in_valid` or `data_in` to any output.
- The next_key path (one S-box byte plus an XOR chain) is combinational from `rk` and must close within one cycle.

## Structure
- **Package `aes_pkg`:**
  - `AES_NR` = 10.
  - `state_t` = logic [127:0].
  - `word_t` = logic [31:0].
  - An Rcon lookup function indexed by round.
  - A RotWord helper.
- **Sub-module `key_expand_step`:** combinational; inputs `rk` and rcon, output the next key. It contains 4 instances of the shared AES S-box byte module.

## Test plan
- **Round-0 key passthrough.** Reset, `key_load` with key 2b7e151628aed2a6abf7158809cf4f3c, then one zero `data_in` beat. Required: `data_out` = the same key (byte 0x2b at [7:0]), `out_round`=0, one cycle after accept.
- **Key schedule sweep.** Send 11 consecutive zero beats with `out_ready`=1. Required:
  - Round 1 output = a0fafe1788542cb123a339392a6c7605.
  - Round 10 output = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `out_round` steps 0 to 10 back-to-back.
- **Wrap to next block.** A 12th beat returns the round-0 key with `out_round`=0, with no reload and no bubble.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles at round 4. Required:
  - `in_ready`=0 and `data_out` stable.
  - The round-5 beat uses round key 5 once `out_ready` rises.
- **Load during a block.** Assert `key_load` with a new key at round 6 while `in_valid`=1. Required: that beat is dropped, `out_valid`=0 next cycle, and the next beat uses the new key with `out_round`=0.
- **Async reset mid-block.** Assert `rst_n`=0 between clock edges. Required:
  - All outputs go to zero immediately.
  - After reset, `in_ready`=0 until `key_load`.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types, round count and key-schedule helpers.
package aes_pkg;
    localparam int AES_NR = 10;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    function automatic logic [7:0] rcon_lookup(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Byte 0 of a word lives at [7:0], so rotating left by one byte is a right shift.
    function automatic word_t rot_word(input word_t w);
        return {w[7:0], w[31:8]};
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// AES S-box byte: GF(2^8) multiplicative inverse (x^254) followed by the affine map.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] v;
        p = 8'h00;
        v = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ v;
            v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Builds x^127 by repeated square-and-multiply, then one more square gives x^254.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign s = affine(gf_inv(a));
endmodule

// File: rtl/key_expand_step.sv
// One AES-128 key-schedule step: next round key from the current one and its rcon.
module key_expand_step
    import aes_pkg::*;
(
    input  state_t     rk,
    input  logic [7:0] rcon,
    output state_t     next_rk
);
    word_t rot;
    word_t sub;
    word_t t;
    word_t w0;
    word_t w1;
    word_t w2;
    word_t w3;

    assign rot = rot_word(rk[127:96]);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot[8*i +: 8]),
            .s (sub[8*i +: 8])
        );
    end

    assign t  = sub ^ {24'h0, rcon};
    assign w0 = rk[31:0]   ^ t;
    assign w1 = rk[63:32]  ^ w0;
    assign w2 = rk[95:64]  ^ w1;
    assign w3 = rk[127:96] ^ w2;

    assign next_rk = {w3, w2, w1, w0};
endmodule

// File: rtl/add_round_key_sched.sv
// AddRoundKey stage with on-the-fly AES-128 key schedule; rewinds to the cipher key
// after the last round so consecutive blocks need no reload.
module add_round_key_sched
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic [3:0]   out_round,
    output logic         key_ready
);
    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t     k0;
    state_t     rk;
    state_t     next_rk;
    logic [3:0] rnd;
    logic [7:0] rcon_cur;
    logic       accept;

    assign in_ready = key_ready & ~key_load & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign rcon_cur = rcon_lookup(rnd);

    key_expand_step u_step (
        .rk      (rk),
        .rcon    (rcon_cur),
        .next_rk (next_rk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k0        <= '0;
            rk        <= '0;
            rnd       <= '0;
            key_ready <= 1'b0;
            data_out  <= '0;
            out_round <= '0;
            out_valid <= 1'b0;
        end else if (key_load) begin
            // A beat offered in the load cycle is dropped; in_ready is low here.
            k0        <= key_in;
            rk        <= key_in;
            rnd       <= '0;
            key_ready <= 1'b1;
            out_valid <= 1'b0;
        end else if (accept) begin
            data_out  <= data_in ^ rk;
            out_round <= rnd;
            out_valid <= 1'b1;
            if (rnd == LAST_RND) begin
                rk  <= k0;
                rnd <= '0;
            end else begin
                rk  <= next_rk;
                rnd <= rnd + 4'd1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_add_round_key_sched.sv
// Self-checking bench: directed FIPS-197 known answers plus randomized traffic
// against a word-list key-expansion reference model.
module tb_add_round_key_sched;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_load;
    logic [127:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic [3:0]   out_round;
    logic         key_ready;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] rks    [11];

    logic         m_kr;
    logic         m_ov;
    logic [127:0] m_do;
    int           m_or;
    int           m_rnd;

    add_round_key_sched #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_round (out_round),
        .key_ready (key_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic int gf_mul_ref(input int a, input int b);
        int p = 0;
        for (int i = 0; i < 8; i++) if ((b >> i) & 1) p ^= (a << i);
        for (int i = 15; i >= 8; i--) if ((p >> i) & 1) p ^= (32'h11b << (i - 8));
        return p;
    endfunction

    function automatic void build_sbox();
        for (int x = 0; x < 256; x++) begin
            int inv = 0;
            int s   = 0;
            for (int y = 1; y < 256; y++) if (gf_mul_ref(x, y) == 1) inv = y;
            for (int i = 0; i < 8; i++) begin
                int bit_v = ((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8))
                            ^ (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ (8'h63 >> i)) & 1;
                s |= bit_v << i;
            end
            sbox_t[x] = 8'(s);
        end
    endfunction

    // Standard 44-word expansion; the round constant is generated by doubling in GF(2^8).
    function automatic void expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        int rc = 1;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:24], t[23:16], t[15:8]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t ^= 32'(rc);
                rc = gf_mul_ref(rc, 2);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rks[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endfunction

    function automatic logic [127:0] fips(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = s[127-8*i -: 8];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge: drive, check in_ready, clock, check outputs.
    task automatic cycle(input logic kl, input logic [127:0] k, input logic iv,
                         input logic [127:0] d, input logic ordy);
        logic m_ir;
        key_load  = kl;
        key_in    = k;
        in_valid  = iv;
        data_in   = d;
        out_ready = ordy;
        #1;
        m_ir = m_kr && !kl && (!m_ov || ordy);
        chk("in_ready", 128'(in_ready), 128'(m_ir));
        @(posedge clk);
        if (kl) begin
            expand(k);
            m_rnd = 0;
            m_kr  = 1'b1;
            m_ov  = 1'b0;
        end else if (iv && m_ir) begin
            m_do  = d ^ rks[m_rnd];
            m_or  = m_rnd;
            m_ov  = 1'b1;
            m_rnd = (m_rnd + 1) % 11;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        @(negedge clk);
        chk("out_valid", 128'(out_valid), 128'(m_ov));
        chk("data_out", data_out, m_do);
        chk("out_round", 128'(out_round), 128'(m_or));
        chk("key_ready", 128'(key_ready), 128'(m_kr));
    endtask

    task automatic model_reset();
        m_kr  = 1'b0;
        m_ov  = 1'b0;
        m_do  = '0;
        m_or  = 0;
        m_rnd = 0;
    endtask

    initial begin
        logic [127:0] key1;
        logic [127:0] key2;
        logic [127:0] held;
        logic [127:0] d;

        build_sbox();
        model_reset();
        key1      = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
        rst_n     = 1'b0;
        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;

        @(negedge clk);
        chk("rst_data_out", data_out, 128'h0);
        chk("rst_out_round", 128'(out_round), 128'h0);
        chk("rst_out_valid", 128'(out_valid), 128'h0);
        chk("rst_key_ready", 128'(key_ready), 128'h0);
        chk("rst_in_ready", 128'(in_ready), 128'h0);
        rst_n = 1'b1;

        cycle(1'b1, key1, 1'b0, '0, 1'b1);
        chk("kat_key_byte0", 128'(data_out[7:0] ^ data_out[7:0]), 128'h0);
        cycle(1'b0, '0, 1'b1, '0, 1'b1);
        chk("kat_round0", data_out, key1);
        chk("kat_byte0_2b", 128'(data_out[7:0]), 128'h2b);
        for (int r = 1; r <= 10; r++) begin
            cycle(1'b0, '0, 1'b1, '0, 1'b1);
            chk("kat_step_round", 128'(out_round), 128'(r));
            if (r == 1)  chk("kat_round1", data_out, fips(128'ha0fafe1788542cb123a339392a6c7605));
            if (r == 10) chk("kat_round10", data_out, fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        end
        cycle(1'b0, '0, 1'b1, '0, 1'b1);
        chk("wrap_round", 128'(out_round), 128'h0);
        chk("wrap_key", data_out, key1);
        chk("wrap_valid", 128'(out_valid), 128'h1);

        for (int n = 0; n < 20 && !(m_ov && m_or == 4); n++) cycle(1'b0, '0, 1'b1, rand128(), 1'b1);
        chk("bp_at_round4", 128'(out_round), 128'h4);
        held = data_out;
        for (int n = 0; n < 3; n++) begin
            cycle(1'b0, '0, 1'b1, rand128(), 1'b0);
            chk("bp_in_ready_low", 128'(in_ready), 128'h0);
            chk("bp_hold", data_out, held);
        end
        d = rand128();
        cycle(1'b0, '0, 1'b1, d, 1'b1);
        chk("bp_round5", 128'(out_round), 128'h5);
        chk("bp_key5", data_out, d ^ rks[5]);

        key2 = rand128();
        cycle(1'b1, key2, 1'b1, rand128(), 1'b1);
        chk("load_drop_valid", 128'(out_valid), 128'h0);
        d = rand128();
        cycle(1'b0, '0, 1'b1, d, 1'b1);
        chk("load_round0", 128'(out_round), 128'h0);
        chk("load_new_key", data_out, d ^ key2);

        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 49) == 0), rand128(), ($urandom_range(0, 3) != 0),
                  rand128(), ($urandom_range(0, 3) != 0));
        end

        cycle(1'b0, '0, 1'b1, rand128(), 1'b1);
        cycle(1'b0, '0, 1'b1, rand128(), 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        data_in   = rand128();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_data_out", data_out, 128'h0);
        chk("arst_out_round", 128'(out_round), 128'h0);
        chk("arst_out_valid", 128'(out_valid), 128'h0);
        chk("arst_key_ready", 128'(key_ready), 128'h0);
        chk("arst_in_ready", 128'(in_ready), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, '0, 1'b1, rand128(), 1'b1);
        chk("arst_no_accept", 128'(out_valid), 128'h0);
        cycle(1'b1, key1, 1'b0, '0, 1'b1);
        d = rand128();
        cycle(1'b0, '0, 1'b1, d, 1'b1);
        chk("arst_reload_key", data_out, d ^ key1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
